regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Multi-port, parametrised integer register file for the pipelined core, replacing the single-write/dual-read file. It supports configurable read and write port counts and a hardwired zero register. A per-register scoreboard of pending-write busy bits lets the issue stage detect RAW hazards. After reset, a sequential clear engine zeroes the array one entry per cycle so the array can map to distributed RAM.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, number of registers (<= 2**ADDR_WIDTH)
NUM_RD, 3, number of read ports
NUM_WR, 2, number of write ports

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset; synchronous, active-high
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_WIDTH  packed write addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
wr_data  in  NUM_WR*DATA_WIDTH  packed write data
rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses
rd_data  out  NUM_RD*DATA_WIDTH  packed read data
rd_busy  out  NUM_RD  busy bit of each read address
iss_en  in  1  issue of an instruction with a destination register
iss_dest  in  ADDR_WIDTH  destination of the issued instruction
init_done  out  1  high once the clear sweep has finished

Behaviour:
- FSM states are CLEAR and READY.
- rst=1 at a posedge: state becomes CLEAR, clr_idx=0, init_done=0, all busy bits=0.
- Reset applies at any time. Reset mid-sweep or mid-operation restarts the sweep from index 0.
- In CLEAR, each cycle: reg[clr_idx]<=0, then clr_idx++.
  - When clr_idx==NUM_REGS-1, the state moves to READY and init_done goes high at the next edge.
  - The sweep takes exactly NUM_REGS cycles after rst deasserts.
  - wr_en and iss_en are ignored in CLEAR.
- While init_done=0, rd_data=0 and rd_busy=0.
- Reads are combinational (0-cycle latency).
  - rd_data[i]=reg[rd_addr[i]].
  - Address 0 always reads 0.
  - Addresses >= NUM_REGS read 0.
- Writes are captured at posedge in READY when wr_en[k]=1.
  - Writes to address 0 or to addresses >= NUM_REGS are dropped.
  - If two ports write the same address in the same cycle, the highest-index port wins.
- Scoreboard, one busy bit per register:
  - Any accepted write clears busy[wr_addr].
  - iss_en with iss_dest!=0 sets busy[iss_dest].
  - If an issue and a write target the same address in the same cycle, set wins (busy stays 1).
  - busy[0] is constant 0.
- rd_busy[i]=busy[rd_addr[i]] (registered state, no forwarding unless the feature below is enabled).

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: in READY, if wr_en[k] is high and wr_addr[k]==rd_addr[i]!=0 in the same cycle:
  - rd_data[i] returns wr_data[k], with the highest-index matching port winning.
  - rd_busy[i] reads 0, unless iss_en is also setting that address in the same cycle.
- Undefined: reads return the pre-write array value and the registered busy bit; the new value is visible the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - the state enum rf_state_e {RF_CLEAR, RF_READY};
  - default width constants;
  - a function that extracts a packed slice by port index.
- One sub-module, regfile_rd_port, instantiated NUM_RD times. It holds the read mux, zero/out-of-range masking, the init_done gating and, under the macro, the bypass priority logic.

Test Plan:
- Reset sweep: preload via writes, pulse rst for 1 cycle.
  - init_done stays 0 for 32 cycles, then 1.
  - All addresses read 0.
  - A write issued during the sweep is lost.
- Port conflict: wr_en=2'b11, both ports to x5, data 0xAAAA0000 (port0) and 0x5555FFFF (port1).
  - x5 reads 0x5555FFFF next cycle.
- Zero register: write 0xDEADBEEF to x0.
  - All read ports addressing x0 return 0 and rd_busy=0.
- Scoreboard: iss_en to x7, then 3 idle cycles, then a write to x7.
  - rd_busy for x7 is 1 during the idle cycles and 0 after the write edge.
  - A same-cycle iss_en to x7 during the write keeps busy at 1.
- Mid-sweep reset: assert rst at sweep cycle 10.
  - init_done rises exactly 32 cycles after the second rst deasserts.
- Bypass: write x3=0x12345678 while reading x3.
  - With REGFILE_BYPASS_EN: the same-cycle read returns 0x12345678.
  - Without it: the same-cycle read returns the old value and the next cycle returns 0x12345678.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port scoreboarded register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_NUM_REGS   = 32;
  localparam int unsigned RF_NUM_RD     = 3;
  localparam int unsigned RF_NUM_WR     = 2;

  // Widest packed port bus and widest single field the helper handles.
  localparam int unsigned RF_VEC_MAX   = 1024;
  localparam int unsigned RF_SLICE_MAX = 64;

  // Field idx of width w from a packed per-port bus; callers size-cast
  // the bus up to RF_VEC_MAX and the result down to their field width.
  function automatic logic [RF_SLICE_MAX-1:0] port_slice(
    input logic [RF_VEC_MAX-1:0] vec,
    input int unsigned           idx,
    input int unsigned           w
  );
    logic [RF_VEC_MAX-1:0] sh;
    sh = vec >> (idx * w);
    return RF_SLICE_MAX'(sh) & ((RF_SLICE_MAX'(1) << w) - RF_SLICE_MAX'(1));
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: mux, zero/out-of-range masking, init gating.
// Same-cycle write bypass is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = RF_NUM_REGS
`ifdef REGFILE_BYPASS_EN
  ,
  parameter int unsigned NUM_WR     = RF_NUM_WR
`endif
) (
  input  logic [NUM_REGS*DATA_WIDTH-1:0] rf_flat,
  input  logic [NUM_REGS-1:0]            busy,
  input  logic                           init_done,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
`ifdef REGFILE_BYPASS_EN
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_dest,
`endif
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_busy
);

  logic valid_addr;

  always_comb begin
    rd_data    = '0;
    rd_busy    = 1'b0;
    valid_addr = (rd_addr != '0) && (32'(rd_addr) < 32'(NUM_REGS));
    if (init_done && valid_addr) begin
      rd_data = rf_flat[rd_addr*DATA_WIDTH +: DATA_WIDTH];
      rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan so the highest-index matching write port wins.
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] &&
            ADDR_WIDTH'(port_slice(RF_VEC_MAX'(wr_addr), k, ADDR_WIDTH)) == rd_addr) begin
          rd_data = DATA_WIDTH'(port_slice(RF_VEC_MAX'(wr_data), k, DATA_WIDTH));
          rd_busy = iss_en && (iss_dest == rd_addr);
        end
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with hardwired x0, pending-write scoreboard and a
// post-reset clear sweep. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = RF_NUM_REGS,
  parameter int unsigned NUM_RD     = RF_NUM_RD,
  parameter int unsigned NUM_WR     = RF_NUM_WR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_dest,
  output logic                         init_done
);

  rf_state_e             state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [NUM_REGS*DATA_WIDTH-1:0] rf_flat;

  logic [ADDR_WIDTH-1:0] wa [NUM_WR];
  logic [DATA_WIDTH-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0]     wr_ok;
  logic                  iss_ok;

  always_comb begin
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wa[k]    = ADDR_WIDTH'(port_slice(RF_VEC_MAX'(wr_addr), k, ADDR_WIDTH));
      wd[k]    = DATA_WIDTH'(port_slice(RF_VEC_MAX'(wr_data), k, DATA_WIDTH));
      wr_ok[k] = wr_en[k] && (state == RF_READY) && (wa[k] != '0) &&
                 (32'(wa[k]) < 32'(NUM_REGS));
    end
    iss_ok = iss_en && (state == RF_READY) && (iss_dest != '0) &&
             (32'(iss_dest) < 32'(NUM_REGS));
  end

  // Clears are applied before the issue set so that set wins on a collision.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_ok[k]) busy_nxt[wa[k]] = 1'b0;
    end
    if (iss_ok) busy_nxt[iss_dest] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_CLEAR;
      clr_idx   <= '0;
      init_done <= 1'b0;
      busy      <= '0;
    end else begin
      case (state)
        RF_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == ADDR_WIDTH'(NUM_REGS - 1)) begin
            state     <= RF_READY;
            init_done <= 1'b1;
          end
        end
        RF_READY: busy <= busy_nxt;
        default:  state <= RF_CLEAR;
      endcase
    end
  end

  // Array has no reset so it can map to distributed RAM; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wr_ok[k]) regs[wa[k]] <= wd[k];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      rf_flat[r*DATA_WIDTH +: DATA_WIDTH] = regs[r];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
`ifdef REGFILE_BYPASS_EN
      ,
      .NUM_WR     (NUM_WR)
`endif
    ) u_rd (
      .rf_flat   (rf_flat),
      .busy      (busy),
      .init_done (init_done),
      .rd_addr   (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
`ifdef REGFILE_BYPASS_EN
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_en    (iss_en),
      .iss_dest  (iss_dest),
`endif
      .rd_data   (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_busy   (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default parameters).
module tb_regfile_mp_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;
  localparam int unsigned NRD = 3;
  localparam int unsigned NWR = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*DW-1:0]   wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_en;
  logic [AW-1:0]       iss_dest;
  logic                init_done;

  int total = 0;
  int bad   = 0;
  int cyc;

  regfile_mp_sb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .NUM_RD     (NRD),
    .NUM_WR     (NWR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_en    (iss_en),
    .iss_dest  (iss_dest),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic set_wr(input int unsigned k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[k]            = 1'b1;
    wr_addr[k*AW +: AW] = a;
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int unsigned i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rdd(input int unsigned i);
    return rd_data[i*DW +: DW];
  endfunction

  // Counts edges after rst deasserts until init_done; -1 if bound expires.
  // At cycle inject_at a write and an issue to x9 are driven for one cycle.
  task automatic sweep(input int inject_at, output int n);
    n = -1;
    for (int c = 1; c <= 64; c++) begin
      step();
      if (c == inject_at) begin
        set_wr(0, 5'd9, 32'h1111_9999);
        iss_en   = 1'b1;
        iss_dest = 5'd9;
      end else begin
        idle_in();
      end
      if (init_done) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; iss_en = 1'b0; iss_dest = '0;

    // Reset state
    set_rd(0, 5'd1);
    step();
    #1;
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rd_busy", 64'(rd_busy), 64'd0);
    check("rst_rd_data", 64'(rdd(0)), 64'd0);
    rst = 1'b0;
    sweep(-10, cyc);
    check("sweep_len_first", 64'(cyc), 64'd32);

    // Preload, both ports in one cycle
    set_wr(0, 5'd1, 32'h1111_1111);
    set_wr(1, 5'd2, 32'h2222_2222);
    step(); idle_in();
    set_wr(0, 5'd4, 32'h4444_4444);
    step(); idle_in();
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd4);
    #1;
    check("preload_x1", 64'(rdd(0)), 64'h1111_1111);
    check("preload_x2", 64'(rdd(1)), 64'h2222_2222);
    check("preload_x4", 64'(rdd(2)), 64'h4444_4444);

    // Port conflict: highest-index port wins
    set_wr(0, 5'd5, 32'hAAAA_0000);
    set_wr(1, 5'd5, 32'h5555_FFFF);
    step(); idle_in();
    set_rd(0, 5'd5);
    #1;
    check("conflict_x5", 64'(rdd(0)), 64'h5555_FFFF);

    // Zero register: write and issue to x0 are both dropped
    set_wr(1, 5'd0, 32'hDEAD_BEEF);
    iss_en = 1'b1; iss_dest = 5'd0;
    step(); idle_in();
    set_rd(0, 5'd0); set_rd(1, 5'd0); set_rd(2, 5'd0);
    #1;
    check("x0_p0", 64'(rdd(0)), 64'd0);
    check("x0_p1", 64'(rdd(1)), 64'd0);
    check("x0_p2", 64'(rdd(2)), 64'd0);
    check("x0_busy", 64'(rd_busy), 64'd0);

    // Scoreboard on x7
    set_rd(2, 5'd7);
    iss_en = 1'b1; iss_dest = 5'd7;
    step(); idle_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sb_busy_idle", 64'(rd_busy[2]), 64'd1);
      step();
    end
    set_wr(0, 5'd7, 32'h0000_0077);
    step(); idle_in();
    check("sb_busy_after_wr", 64'(rd_busy[2]), 64'd0);
    check("sb_data_after_wr", 64'(rdd(2)), 64'h0000_0077);
    set_wr(1, 5'd7, 32'h0000_0078);
    iss_en = 1'b1; iss_dest = 5'd7;
    step(); idle_in();
    check("sb_set_wins", 64'(rd_busy[2]), 64'd1);
    check("sb_set_wins_data", 64'(rdd(2)), 64'h0000_0078);

    // Same-cycle write/read of x3, with x3 pending
    set_wr(0, 5'd3, 32'hCAFE_0003);
    iss_en = 1'b1; iss_dest = 5'd3;
    step(); idle_in();
    set_rd(1, 5'd3);
    set_wr(1, 5'd3, 32'h1234_5678);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_data", 64'(rdd(1)), 64'h1234_5678);
    check("byp_same_busy", 64'(rd_busy[1]), 64'd0);
`else
    check("byp_same_data", 64'(rdd(1)), 64'hCAFE_0003);
    check("byp_same_busy", 64'(rd_busy[1]), 64'd1);
`endif
    step(); idle_in();
    check("byp_next_data", 64'(rdd(1)), 64'h1234_5678);
    check("byp_next_busy", 64'(rd_busy[1]), 64'd0);

    // Reset pulse with preloaded values and x7 still busy
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_rd(2, 5'd7);
    #1;
    check("rst2_init_done", 64'(init_done), 64'd0);
    check("rst2_busy", 64'(rd_busy), 64'd0);
    sweep(30, cyc);
    check("sweep_len_preload", 64'(cyc), 64'd32);
    for (int a = 0; a < 32; a++) begin
      set_rd(a % 3, a[AW-1:0]);
      #1;
      check("post_rst_zero", 64'(rdd(a % 3)), 64'd0);
    end
    set_rd(0, 5'd9); set_rd(2, 5'd7);
    #1;
    check("sweep_write_lost", 64'(rdd(0)), 64'd0);
    check("sweep_iss_lost", 64'(rd_busy), 64'd0);

    // Mid-sweep reset restarts from index 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_sweep_not_done", 64'(init_done), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep(-10, cyc);
    check("sweep_len_restart", 64'(cyc), 64'd32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
